reg_pair_writeback: RTL and testbench

- Write-back stage sitting directly downstream of the 1-to-2 register-select decoder in the fdt16 CPU datapath.
- Accepts 16-bit write requests tagged with a 1-bit register select.
- Buffers them in a small in-order queue and commits them to the two architectural registers (R0, R1) when the pipeline allows.
- Exposes the current register values to the execute stage.

---
 rtl/reg_pair_writeback.sv | 121 ++++++++++++
 tb/tb_reg_pair_writeback.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_pair_writeback.sv
// Write-back stage: in-order queue committing to R0/R1.
// Optional REG_BYPASS_EN forwards queued writes to reg0/reg1.
module reg_pair_writeback #(
  parameter int DATA_WIDTH  = 16,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic                          wr_select,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          commit_en,
  input  logic                          flush,
  output logic [DATA_WIDTH-1:0]         reg0,
  output logic [DATA_WIDTH-1:0]         reg1,
  output logic [$clog2(QUEUE_DEPTH):0]  pending,
  output logic                          commit_valid,
  output logic                          commit_select
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  logic                  q_sel  [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] r0;
  logic [DATA_WIDTH-1:0] r1;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full     = (count == CW'(QUEUE_DEPTH));
  assign empty    = (count == '0);
  // ready ignores a same-cycle commit on purpose
  assign wr_ready = !full && !flush && !rst;
  assign push     = wr_valid && wr_ready;
  assign pop      = commit_en && !empty && !flush;
  assign pending  = count;

  // queue storage; contents are meaningless outside [head, tail)
  always_ff @(posedge clk) begin
    if (push) begin
      q_sel[tail]  <= wr_select;
      q_data[tail] <= wr_data;
    end
  end

  // pointers, occupancy, architectural registers and commit pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      r0            <= '0;
      r1            <= '0;
      commit_valid  <= 1'b0;
      commit_select <= 1'b0;
    end else if (flush) begin
      head         <= tail;
      count        <= '0;
      commit_valid <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head          <= head + PW'(1);
        commit_valid  <= 1'b1;
        commit_select <= q_sel[head];
        if (q_sel[head]) begin
          r1 <= q_data[head];
        end else begin
          r0 <= q_data[head];
        end
      end else begin
        commit_valid <= 1'b0;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef REG_BYPASS_EN
  logic [DATA_WIDTH-1:0] byp0;
  logic [DATA_WIDTH-1:0] byp1;
  logic [PW-1:0]         idx;

  // walk oldest to youngest so the youngest match wins
  always_comb begin
    byp0 = r0;
    byp1 = r1;
    idx  = head;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) begin
        if (q_sel[idx]) begin
          byp1 = q_data[idx];
        end else begin
          byp0 = q_data[idx];
        end
      end
    end
  end

  assign reg0 = byp0;
  assign reg1 = byp1;
`else
  assign reg0 = r0;
  assign reg1 = r1;
`endif

endmodule

// File: tb/tb_reg_pair_writeback.sv
// Directed bench for reg_pair_writeback.
// Expectations follow REG_BYPASS_EN when it is defined.
module tb_reg_pair_writeback;

`ifdef REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_select;
  logic [15:0] wr_data;
  logic        commit_en;
  logic        flush;
  logic [15:0] reg0;
  logic [15:0] reg1;
  logic [1:0]  pending;
  logic        commit_valid;
  logic        commit_select;

  int total = 0;
  int bad   = 0;

  reg_pair_writeback #(
    .DATA_WIDTH(16),
    .QUEUE_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_select(wr_select),
    .wr_data(wr_data),
    .commit_en(commit_en),
    .flush(flush),
    .reg0(reg0),
    .reg1(reg1),
    .pending(pending),
    .commit_valid(commit_valid),
    .commit_select(commit_select)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s,
                       input logic [15:0] d, input logic ce,
                       input logic fl);
    wr_valid  = v;
    wr_select = s;
    wr_data   = d;
    commit_en = ce;
    flush     = fl;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 16'h0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reg0", 32'(reg0), 32'h0);
    chk("rst_reg1", 32'(reg1), 32'h0);
    chk("rst_pend", 32'(pending), 32'h0);
    chk("rst_rdy", 32'(wr_ready), 32'h0);
    chk("rst_cv", 32'(commit_valid), 32'h0);
    chk("rst_cs", 32'(commit_select), 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_rdy", 32'(wr_ready), 32'h1);

    // single write, committed one edge after acceptance
    drive(1, 0, 16'h1234, 1, 0);
    step();
    chk("w1_pend", 32'(pending), 32'h1);
    chk("w1_cv0", 32'(commit_valid), 32'h0);
    chk("w1_reg0a", 32'(reg0), BYP ? 32'h1234 : 32'h0);
    drive(0, 0, 16'h0, 1, 0);
    step();
    chk("w1_reg0", 32'(reg0), 32'h1234);
    chk("w1_pend0", 32'(pending), 32'h0);
    chk("w1_cv", 32'(commit_valid), 32'h1);
    chk("w1_cs", 32'(commit_select), 32'h0);
    step();
    chk("w1_cv_end", 32'(commit_valid), 32'h0);

    // fill with commits stalled
    drive(1, 1, 16'hAAAA, 0, 0);
    step();
    drive(1, 1, 16'h5555, 0, 0);
    step();
    chk("fill_pend", 32'(pending), 32'h2);
    chk("fill_reg1", 32'(reg1), BYP ? 32'h5555 : 32'h0);
    drive(1, 1, 16'h7777, 1, 0);
    #1;
    chk("full_rdy", 32'(wr_ready), 32'h0);
    step();
    chk("drain1_pend", 32'(pending), 32'h1);
    chk("drain1_reg1", 32'(reg1), BYP ? 32'h5555 : 32'hAAAA);
    chk("drain1_cv", 32'(commit_valid), 32'h1);
    chk("drain1_cs", 32'(commit_select), 32'h1);
    drive(0, 0, 16'h0, 1, 0);
    step();
    chk("drain2_pend", 32'(pending), 32'h0);
    chk("drain2_reg1", 32'(reg1), 32'h5555);
    chk("drain2_cv", 32'(commit_valid), 32'h1);
    step();
    chk("empty_cv", 32'(commit_valid), 32'h0);
    chk("empty_cs", 32'(commit_select), 32'h1);
    chk("empty_pend", 32'(pending), 32'h0);
    chk("refused_reg1", 32'(reg1), 32'h5555);

    // push and commit in the same cycle
    drive(1, 0, 16'h4444, 0, 0);
    step();
    chk("pc_pend1", 32'(pending), 32'h1);
    drive(1, 0, 16'h0F0F, 1, 0);
    step();
    chk("pc_pend", 32'(pending), 32'h1);
    chk("pc_reg0a", 32'(reg0), BYP ? 32'h0F0F : 32'h4444);
    chk("pc_cs", 32'(commit_select), 32'h0);
    drive(0, 0, 16'h0, 1, 0);
    step();
    chk("pc_reg0b", 32'(reg0), 32'h0F0F);
    chk("pc_pend0", 32'(pending), 32'h0);

    // flush discards queued writes and blocks the push
    drive(1, 0, 16'hBEEF, 0, 0);
    step();
    drive(1, 1, 16'hCAFE, 0, 0);
    step();
    chk("fl_pend2", 32'(pending), 32'h2);
    drive(1, 0, 16'hDEAD, 1, 1);
    #1;
    chk("fl_rdy", 32'(wr_ready), 32'h0);
    step();
    chk("fl_pend", 32'(pending), 32'h0);
    chk("fl_reg0", 32'(reg0), 32'h0F0F);
    chk("fl_reg1", 32'(reg1), 32'h5555);
    chk("fl_cv", 32'(commit_valid), 32'h0);
    drive(0, 0, 16'h0, 1, 0);
    step();
    chk("fl_cv2", 32'(commit_valid), 32'h0);
    chk("fl_reg0b", 32'(reg0), 32'h0F0F);
    chk("fl_pend0", 32'(pending), 32'h0);

    // asynchronous reset with a loaded queue
    drive(1, 0, 16'h1234, 1, 0);
    step();
    drive(0, 0, 16'h0, 1, 0);
    step();
    chk("ar_reg0", 32'(reg0), 32'h1234);
    drive(1, 0, 16'h1111, 0, 0);
    step();
    drive(1, 1, 16'h2222, 0, 0);
    step();
    drive(0, 0, 16'h0, 0, 0);
    chk("ar_pend2", 32'(pending), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_pend", 32'(pending), 32'h0);
    chk("ar_reg0z", 32'(reg0), 32'h0);
    chk("ar_reg1z", 32'(reg1), 32'h0);
    chk("ar_rdy", 32'(wr_ready), 32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("ar_rdy1", 32'(wr_ready), 32'h1);

    // queued writes are visible early only with the bypass
    drive(1, 1, 16'h0001, 0, 0);
    #1;
    chk("bp_nosame", 32'(reg1), 32'h0);
    step();
    drive(1, 1, 16'h0002, 0, 0);
    step();
    drive(0, 0, 16'h0, 0, 0);
    chk("bp_reg1", 32'(reg1), BYP ? 32'h0002 : 32'h0);
    chk("bp_reg0", 32'(reg0), 32'h0);
    drive(0, 0, 16'h0, 1, 0);
    step();
    chk("bp_c1", 32'(reg1), BYP ? 32'h0002 : 32'h0001);
    step();
    chk("bp_c2", 32'(reg1), 32'h0002);
    chk("bp_pend", 32'(pending), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
